// File: rtl/k051962_plane_serializer.sv
// k051962_plane_serializer: per-plane tile-row serializer with a two-tile window
// and fine horizontal scroll. It emits one 4-bit colour index and its attribute per pixel enable.
module k051962_plane_serializer (
    input  logic        clk_24M,
    input  logic        nRES,
    input  logic        PIX_CE,
    input  logic        TILE_LD,
    input  logic [31:0] ROM_D,
    input  logic [7:0]  COL_IN,
    input  logic [2:0]  FINE,
    input  logic        FLIPX_EN,
    input  logic        FLIP_SCREEN,
    input  logic        BLANK,
    output logic [3:0]  PIX,
    output logic [7:0]  PIX_COL,
    output logic        OPAQUE
);
    logic [31:0] cur, nxt, rom_f, src;
    logic [7:0]  cur_col, nxt_col, sel_col;
    logic [2:0]  p, fq;
    logic [3:0]  idx, sel_pix;
    logic        flip;

    assign flip = (FLIPX_EN & COL_IN[0]) ^ FLIP_SCREEN;

    // Tiles are stored flip-corrected, so the shifter never needs to know about flips.
    always_comb begin
        rom_f = ROM_D;
        for (int k = 0; k < 8; k++)
            rom_f[31-4*k -: 4] = flip ? ROM_D[4*k+3 -: 4] : ROM_D[31-4*k -: 4];
    end

    assign idx     = {1'b0, p} + {1'b0, fq};
    assign src     = idx[3] ? nxt : cur;
    assign sel_col = idx[3] ? nxt_col : cur_col;
    assign sel_pix = src[5'd28 - {idx[2:0], 2'b00} +: 4];

    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            cur     <= '0;
            nxt     <= '0;
            cur_col <= '0;
            nxt_col <= '0;
            p       <= '0;
            fq      <= '0;
            PIX     <= '0;
            PIX_COL <= '0;
            OPAQUE  <= 1'b0;
        end else if (PIX_CE) begin
            PIX     <= BLANK ? 4'd0 : sel_pix;
            PIX_COL <= BLANK ? 8'd0 : sel_col;
            OPAQUE  <= !BLANK && (sel_pix != 4'd0);
            if (TILE_LD) begin
                cur     <= nxt;
                cur_col <= nxt_col;
                nxt     <= rom_f;
                nxt_col <= COL_IN;
                p       <= '0;
                fq      <= FINE;
            end else begin
                p <= p + 3'd1;
            end
        end
    end
endmodule
